// File: rtl/jzjcoref_mmio_pkg.sv
// Shared definitions for the memory-mapped GPIO bank: register offsets inside a
// port block, block size and the byte-lane mask helper.
package jzjcoref_mmio_pkg;

    typedef enum logic [1:0] {
        IN  = 2'd0,
        OUT = 2'd1,
        DIR = 2'd2,
        EVT = 2'd3
    } MMIO_OFFSET;

    localparam int MMIO_BLOCK_BYTES = 16;

    function automatic logic [31:0] byteMask(input logic [3:0] byteEnable);
        logic [31:0] mask;
        mask = '0;
        for (int k = 0; k < 4; k++) begin
            mask[8*k +: 8] = {8{byteEnable[k]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/mmio_input_sync.sv
// One port's input path: synchroniser chain, previous-sample register and the
// sticky change-event register with write-one-to-clear.
module mmio_input_sync
    import jzjcoref_mmio_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] rawIn,
    input  logic [31:0] dir,
    input  logic [31:0] w1cMask,
    input  logic        w1cValid,
    output logic [31:0] syncIn,
    output logic [31:0] evt
);

    logic [31:0] syncChain [SYNC_STAGES];
    logic [31:0] prevIn;
    logic [31:0] clearMask;

    assign clearMask = w1cValid ? w1cMask : 32'h0;
    assign syncIn    = syncChain[SYNC_STAGES-1];

    // A change detected in the same cycle as a clear of that bit keeps the bit set.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                syncChain[i] <= '0;
            end
            prevIn <= '0;
            evt    <= '0;
        end else begin
            syncChain[0] <= rawIn;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                syncChain[i] <= syncChain[i-1];
            end
            prevIn <= syncIn;
            evt    <= (evt & ~clearMask) | ((syncIn ^ prevIn) & ~dir);
        end
    end

endmodule

// File: rtl/mmio_port_bank.sv
// Parametrised memory-mapped GPIO bank: address decode, OUT/DIR registers,
// per-port input synchronisers with sticky events, registered read port and irq.
module mmio_port_bank
    import jzjcoref_mmio_pkg::*;
#(
    parameter int          NUM_PORTS   = 8,
    parameter logic [31:0] BASE_ADDR   = 32'hFFFFFF00,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] OUT_RESET   = 32'h0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [31:0]            address,
    input  logic [31:0]            writeData,
    input  logic [3:0]             byteEnable,
    input  logic                   writeEnable,
    input  logic                   readEnable,
    output logic                   hit,
    output logic [31:0]            readData,
    output logic                   readValid,
    input  logic [NUM_PORTS*32-1:0] portInput,
    output logic [NUM_PORTS*32-1:0] portOutput,
    output logic [NUM_PORTS*32-1:0] portDirection,
    output logic                   irq
);

    localparam logic [32:0] REGION_START = {1'b0, BASE_ADDR};
    localparam logic [32:0] REGION_END   = REGION_START + 33'(NUM_PORTS * MMIO_BLOCK_BYTES);

    if (NUM_PORTS < 1 || NUM_PORTS > 16 || BASE_ADDR[3:0] != 4'h0 ||
        REGION_END > 33'h1_0000_0000 || SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : gBadConfig
        $error("mmio_port_bank: illegal parameter combination");
    end

    // Access protocol: writeEnable/readEnable are single-cycle strobes with no
    // backpressure; a hitting read returns readData with readValid one cycle later.
    logic [31:0]          portOffset;
    MMIO_OFFSET           regSel;
    logic [31:0]          laneMask;
    logic [NUM_PORTS-1:0] portSel;
    logic [31:0]          outReg  [NUM_PORTS];
    logic [31:0]          dirReg  [NUM_PORTS];
    logic [31:0]          syncIn  [NUM_PORTS];
    logic [31:0]          evt     [NUM_PORTS];
    logic [31:0]          readMux;
    logic                 evtAny;

    assign hit        = ({1'b0, address} >= REGION_START) && ({1'b0, address} < REGION_END);
    assign portOffset = (address - BASE_ADDR) >> 4;
    assign regSel     = MMIO_OFFSET'(address[3:2]);
    assign laneMask   = byteMask(byteEnable);

    always_comb begin
        portSel = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            portSel[p] = hit && (portOffset == 32'(p));
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                outReg[p] <= OUT_RESET;
                dirReg[p] <= '0;
            end
        end else if (writeEnable) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (portSel[p] && regSel == OUT) begin
                    outReg[p] <= (outReg[p] & ~laneMask) | (writeData & laneMask);
                end
                if (portSel[p] && regSel == DIR) begin
                    dirReg[p] <= (dirReg[p] & ~laneMask) | (writeData & laneMask);
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : gPort
        mmio_input_sync #(
            .SYNC_STAGES(SYNC_STAGES)
        ) inputSync (
            .clock    (clock),
            .reset    (reset),
            .rawIn    (portInput[32*p +: 32]),
            .dir      (dirReg[p]),
            .w1cMask  (writeData & laneMask),
            .w1cValid (writeEnable && portSel[p] && regSel == EVT),
            .syncIn   (syncIn[p]),
            .evt      (evt[p])
        );

        assign portOutput[32*p +: 32]    = outReg[p];
        assign portDirection[32*p +: 32] = dirReg[p];
    end

    always_comb begin
        readMux = '0;
        evtAny  = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            evtAny = evtAny | (|evt[p]);
            if (portSel[p]) begin
                case (regSel)
                    IN:  readMux = syncIn[p];
                    OUT: readMux = outReg[p];
                    DIR: readMux = dirReg[p];
                    EVT: readMux = evt[p];
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            readData  <= '0;
            readValid <= 1'b0;
            irq       <= 1'b0;
        end else begin
            readValid <= readEnable && hit;
            if (readEnable && hit) begin
                readData <= readMux;
            end
            irq <= evtAny;
        end
    end

endmodule

// File: tb/tb_mmio_port_bank.sv
// Directed bench for mmio_port_bank: reset, byte writes, input sync/event timing,
// direction masking, W1C race, back-to-back reads, miss decode and reset mid-read.
module tb_mmio_port_bank;
    import jzjcoref_mmio_pkg::*;

    localparam int          NUM_PORTS   = 8;
    localparam logic [31:0] BASE_ADDR   = 32'hFFFFFF00;
    localparam int          SYNC_STAGES = 2;
    localparam logic [31:0] OUT_RESET   = 32'h0;

    logic                    clock = 1'b0;
    logic                    reset;
    logic [31:0]             address;
    logic [31:0]             writeData;
    logic [3:0]              byteEnable;
    logic                    writeEnable;
    logic                    readEnable;
    logic                    hit;
    logic [31:0]             readData;
    logic                    readValid;
    logic [NUM_PORTS*32-1:0] portInput;
    logic [NUM_PORTS*32-1:0] portOutput;
    logic [NUM_PORTS*32-1:0] portDirection;
    logic                    irq;

    int compared   = 0;
    int mismatched = 0;
    logic [31:0] exp_q[$];

    mmio_port_bank #(
        .NUM_PORTS   (NUM_PORTS),
        .BASE_ADDR   (BASE_ADDR),
        .SYNC_STAGES (SYNC_STAGES),
        .OUT_RESET   (OUT_RESET)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .address       (address),
        .writeData     (writeData),
        .byteEnable    (byteEnable),
        .writeEnable   (writeEnable),
        .readEnable    (readEnable),
        .hit           (hit),
        .readData      (readData),
        .readValid     (readValid),
        .portInput     (portInput),
        .portOutput    (portOutput),
        .portDirection (portDirection),
        .irq           (irq)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] regAddr(input int p, input logic [1:0] off);
        return BASE_ADDR + 32'(p * 16) + {28'd0, off, 2'b00};
    endfunction

    // Inputs change on the falling edge; the DUT samples on the following rising edge.
    task automatic busWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        address     = addr;
        writeData   = data;
        byteEnable  = be;
        writeEnable = 1'b1;
        @(negedge clock);
        writeEnable = 1'b0;
        byteEnable  = 4'h0;
    endtask

    task automatic busRead(input logic [31:0] addr);
        address    = addr;
        readEnable = 1'b1;
        @(negedge clock);
        readEnable = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) begin
            @(negedge clock);
            portInput = ~portInput;
        end
        address     = BASE_ADDR;
        writeData   = 32'hFFFFFFFF;
        byteEnable  = 4'hF;
        writeEnable = 1'b1;
        readEnable  = 1'b1;
        @(negedge clock);
        compared++; if (readValid !== 1'b0) begin mismatched++; $display("FAIL rst_readValid: got %b want 0", readValid); end
        compared++; if (readData !== 32'h0) begin mismatched++; $display("FAIL rst_readData: got %h want 0", readData); end
        compared++; if (irq !== 1'b0) begin mismatched++; $display("FAIL rst_irq: got %b want 0", irq); end
        compared++; if (portOutput !== {NUM_PORTS{OUT_RESET}}) begin mismatched++; $display("FAIL rst_portOutput: got %h", portOutput); end
        compared++; if (portDirection !== '0) begin mismatched++; $display("FAIL rst_portDirection: got %h", portDirection); end
        compared++; if (hit !== 1'b1) begin mismatched++; $display("FAIL rst_hit_base: got %b want 1", hit); end
        writeEnable = 1'b0;
        readEnable  = 1'b0;
        byteEnable  = 4'h0;
        portInput   = '0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        busRead(regAddr(3, OUT));
        compared++; if (readData !== 32'h0) begin mismatched++; $display("FAIL rst_out_p3: got %h want 0", readData); end
        compared++; if (readValid !== 1'b1) begin mismatched++; $display("FAIL rst_out_p3_valid: got %b want 1", readValid); end
        repeat (3) @(negedge clock);
        compared++; if (irq !== 1'b0) begin mismatched++; $display("FAIL rst_irq_after: got %b want 0", irq); end
    endtask

    task automatic test_byte_write();
        busWrite(regAddr(0, OUT), 32'hAABBCCDD, 4'b1111);
        busWrite(regAddr(0, OUT), 32'h11223344, 4'b0101);
        compared++; if (portOutput[31:0] !== 32'hAA22CC44) begin mismatched++; $display("FAIL bw_portOutput: got %h want aa22cc44", portOutput[31:0]); end
        busWrite(regAddr(0, OUT), 32'h00000000, 4'b0000);
        compared++; if (portOutput[31:0] !== 32'hAA22CC44) begin mismatched++; $display("FAIL bw_be0_noop: got %h want aa22cc44", portOutput[31:0]); end
        busRead(regAddr(0, OUT));
        compared++; if (readData !== 32'hAA22CC44) begin mismatched++; $display("FAIL bw_read: got %h want aa22cc44", readData); end
        compared++; if (readValid !== 1'b1) begin mismatched++; $display("FAIL bw_valid: got %b want 1", readValid); end
        @(negedge clock);
        compared++; if (readValid !== 1'b0) begin mismatched++; $display("FAIL bw_valid_one_cycle: got %b want 0", readValid); end
        busWrite(regAddr(0, IN), 32'hFFFFFFFF, 4'hF);
        busRead(regAddr(0, IN));
        compared++; if (readData !== 32'h0) begin mismatched++; $display("FAIL bw_in_ro: got %h want 0", readData); end
    endtask

    task automatic test_sync_event();
        address    = regAddr(1, IN);
        readEnable = 1'b1;
        portInput[63:32] = 32'h00000081;
        @(negedge clock);
        compared++; if (readData !== 32'h0) begin mismatched++; $display("FAIL se_in_t1: got %h want 0", readData); end
        @(negedge clock);
        compared++; if (readData !== 32'h0) begin mismatched++; $display("FAIL se_in_t2: got %h want 0", readData); end
        @(negedge clock);
        compared++; if (readData !== 32'h00000081) begin mismatched++; $display("FAIL se_in_t3: got %h want 81", readData); end
        compared++; if (irq !== 1'b0) begin mismatched++; $display("FAIL se_irq_t3: got %b want 0", irq); end
        address = regAddr(1, EVT);
        @(negedge clock);
        compared++; if (readData !== 32'h00000081) begin mismatched++; $display("FAIL se_evt_t4: got %h want 81", readData); end
        compared++; if (irq !== 1'b1) begin mismatched++; $display("FAIL se_irq_t4: got %b want 1", irq); end
        readEnable = 1'b0;
        busRead(regAddr(0, EVT));
        compared++; if (readData !== 32'h0) begin mismatched++; $display("FAIL se_evt_p0: got %h want 0", readData); end
    endtask

    task automatic test_dir_mask();
        busWrite(regAddr(2, DIR), 32'h0000FFFF, 4'hF);
        compared++; if (portDirection[95:64] !== 32'h0000FFFF) begin mismatched++; $display("FAIL dm_portDirection: got %h want 0000ffff", portDirection[95:64]); end
        portInput[95:64] = 32'h00010001;
        repeat (4) @(negedge clock);
        busRead(regAddr(2, EVT));
        compared++; if (readData !== 32'h00010000) begin mismatched++; $display("FAIL dm_evt: got %h want 00010000", readData); end
        busRead(regAddr(2, DIR));
        compared++; if (readData !== 32'h0000FFFF) begin mismatched++; $display("FAIL dm_dir_read: got %h want 0000ffff", readData); end
        busWrite(regAddr(2, DIR), 32'hFFFF0000, 4'hF);
        busRead(regAddr(2, EVT));
        compared++; if (readData !== 32'h00010000) begin mismatched++; $display("FAIL dm_evt_persist: got %h want 00010000", readData); end
        busWrite(regAddr(2, EVT), 32'hFFFFFFFF, 4'b0011);
        busRead(regAddr(2, EVT));
        compared++; if (readData !== 32'h00010000) begin mismatched++; $display("FAIL dm_w1c_lanes: got %h want 00010000", readData); end
        busWrite(regAddr(2, EVT), 32'hFFFFFFFF, 4'hF);
        busRead(regAddr(2, EVT));
        compared++; if (readData !== 32'h0) begin mismatched++; $display("FAIL dm_w1c_all: got %h want 0", readData); end
    endtask

    task automatic test_w1c_race();
        busRead(regAddr(1, EVT));
        compared++; if (readData !== 32'h00000081) begin mismatched++; $display("FAIL wr_evt_pre: got %h want 81", readData); end
        portInput[63:32] = 32'h00000080;
        @(negedge clock);
        @(negedge clock);
        busWrite(regAddr(1, EVT), 32'h00000001, 4'hF);
        busRead(regAddr(1, EVT));
        compared++; if (readData !== 32'h00000081) begin mismatched++; $display("FAIL wr_set_wins: got %h want 81", readData); end
        busWrite(regAddr(1, EVT), 32'h00000081, 4'hF);
        compared++; if (irq !== 1'b1) begin mismatched++; $display("FAIL wr_irq_hold: got %b want 1", irq); end
        @(negedge clock);
        compared++; if (irq !== 1'b0) begin mismatched++; $display("FAIL wr_irq_drop: got %b want 0", irq); end
        busRead(regAddr(1, EVT));
        compared++; if (readData !== 32'h0) begin mismatched++; $display("FAIL wr_evt_clear: got %h want 0", readData); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrTab [3];
        logic [31:0] expTab  [3];
        logic [31:0] expected;
        busWrite(regAddr(4, OUT), 32'h11111111, 4'hF);
        busWrite(regAddr(5, OUT), 32'h22222222, 4'hF);
        busWrite(regAddr(6, DIR), 32'h33333333, 4'hF);
        addrTab[0] = regAddr(4, OUT); expTab[0] = 32'h11111111;
        addrTab[1] = regAddr(5, OUT); expTab[1] = 32'h22222222;
        addrTab[2] = regAddr(6, DIR); expTab[2] = 32'h33333333;
        readEnable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            address = addrTab[i];
            exp_q.push_back(expTab[i]);
            @(negedge clock);
            expected = exp_q.pop_front();
            compared++; if (readData !== expected) begin mismatched++; $display("FAIL b2b_read%0d: got %h want %h", i, readData, expected); end
            compared++; if (readValid !== 1'b1) begin mismatched++; $display("FAIL b2b_valid%0d: got %b want 1", i, readValid); end
        end
        address     = regAddr(4, OUT);
        writeData   = 32'hDEADBEEF;
        byteEnable  = 4'hF;
        writeEnable = 1'b1;
        @(negedge clock);
        compared++; if (readData !== 32'h11111111) begin mismatched++; $display("FAIL b2b_rw_old: got %h want 11111111", readData); end
        compared++; if (portOutput[159:128] !== 32'hDEADBEEF) begin mismatched++; $display("FAIL b2b_rw_out: got %h want deadbeef", portOutput[159:128]); end
        writeEnable = 1'b0;
        byteEnable  = 4'h0;
        @(negedge clock);
        compared++; if (readData !== 32'hDEADBEEF) begin mismatched++; $display("FAIL b2b_rw_new: got %h want deadbeef", readData); end
        readEnable = 1'b0;
    endtask

    task automatic test_miss_reset();
        logic [NUM_PORTS*32-1:0] outBefore;
        outBefore  = portOutput;
        address    = BASE_ADDR + 32'(NUM_PORTS * 16);
        readEnable = 1'b1;
        #1;
        compared++; if (hit !== 1'b0) begin mismatched++; $display("FAIL mr_hit_end: got %b want 0", hit); end
        @(negedge clock);
        compared++; if (readValid !== 1'b0) begin mismatched++; $display("FAIL mr_miss_valid: got %b want 0", readValid); end
        compared++; if (readData !== 32'hDEADBEEF) begin mismatched++; $display("FAIL mr_miss_hold: got %h want deadbeef", readData); end
        readEnable = 1'b0;
        address = BASE_ADDR - 32'd4;
        #1;
        compared++; if (hit !== 1'b0) begin mismatched++; $display("FAIL mr_hit_below: got %b want 0", hit); end
        address = BASE_ADDR + 32'(NUM_PORTS * 16) - 32'd4;
        #1;
        compared++; if (hit !== 1'b1) begin mismatched++; $display("FAIL mr_hit_last: got %b want 1", hit); end
        @(negedge clock);
        busWrite(BASE_ADDR + 32'(NUM_PORTS * 16) + 32'd4, 32'h5A5A5A5A, 4'hF);
        compared++; if (portOutput !== outBefore) begin mismatched++; $display("FAIL mr_miss_write: got %h want %h", portOutput, outBefore); end
        busRead(regAddr(0, OUT));
        compared++; if (readValid !== 1'b1) begin mismatched++; $display("FAIL mr_valid_before_rst: got %b want 1", readValid); end
        reset = 1'b0;
        #1;
        compared++; if (readValid !== 1'b0) begin mismatched++; $display("FAIL mr_rst_valid: got %b want 0", readValid); end
        compared++; if (readData !== 32'h0) begin mismatched++; $display("FAIL mr_rst_data: got %h want 0", readData); end
        compared++; if (portOutput[31:0] !== OUT_RESET) begin mismatched++; $display("FAIL mr_rst_out: got %h want %h", portOutput[31:0], OUT_RESET); end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        compared++; if (readValid !== 1'b0) begin mismatched++; $display("FAIL mr_no_replay: got %b want 0", readValid); end
    endtask

    initial begin
        reset       = 1'b0;
        address     = '0;
        writeData   = '0;
        byteEnable  = '0;
        writeEnable = 1'b0;
        readEnable  = 1'b0;
        portInput   = '0;
        test_reset();
        test_byte_write();
        test_sync_event();
        test_dir_mask();
        test_w1c_race();
        test_back_to_back();
        test_miss_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
